// File: rtl/ps2_key_tracker_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker_pkg
//   Shared definitions for the PS/2 key tracker: keyboard scancode constants,
//   the prefix-decoder state type and a small classification helper.
// ----------------------------------------------------------------------------
package ps2_key_tracker_pkg;

  // Scancode set 2 prefixes and the two shift keys.
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Index of the stop bit within a frame (start, 8 data, parity, stop).
  localparam logic [3:0] STOP_BIT_IDX = 4'd10;

  // Prefix decoder: which prefixes (E0 and/or F0) preceded the next byte.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_e;

  // Only the non-extended codes 12/59 are the physical shift keys.
  function automatic logic is_shift_code(input logic [7:0] code, input logic is_ext);
    return !is_ext && ((code == SC_LSHIFT) || (code == SC_RSHIFT));
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
//   Synchronises the raw PS/2 clock/data lines, deframes 11-bit frames
//   (start, 8 data LSB first, odd parity, stop) and discards partial frames
//   after a period of bus inactivity.
//
//   Build option: PS2_PARITY_CHECK_EN -- when defined a parity mismatch
//   rejects the frame; otherwise the parity bit is ignored.
//
//   Ports
//     clk        system clock
//     clrn       asynchronous active-low reset
//     ps2_clk    raw PS/2 clock (asynchronous)
//     ps2_data   raw PS/2 data  (asynchronous)
//     rx_byte    last accepted data byte
//     byte_ok    one-cycle pulse: rx_byte is new
//     frame_err  one-cycle pulse: bad start/stop/parity or timeout
// ----------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_key_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);

`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic [3:0]       bit_cnt_q,  bit_cnt_d;
  logic [9:0]       shreg_q,    shreg_d;
  logic [CNT_W-1:0] tmo_q,      tmo_d;
  logic [7:0]       byte_q,     byte_d;
  logic             byte_ok_q,  byte_ok_d;
  logic             err_q,      err_d;

  logic ps2_fall;
  logic data_bit;
  logic start_ok;
  logic stop_ok;
  logic parity_ok;

  assign ps2_fall = (clk_sync_q[2:1] == 2'b10);
  assign data_bit = data_sync_q[1];

  // After ten shifts: [0] start, [8:1] data, [9] parity; the stop bit is
  // the one being sampled right now.
  assign start_ok  = ~shreg_q[0];
  assign stop_ok   = data_bit;
  assign parity_ok = ~PARITY_EN | (^shreg_q[9:1]);

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no path can
    // leave one unassigned and infer a latch.
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    byte_d    = byte_q;
    byte_ok_d = 1'b0;
    err_d     = 1'b0;

    if (ps2_fall) begin
      // Any edge restarts the inactivity window, even one that coincides
      // with the timeout.
      tmo_d = '0;
      if (bit_cnt_q == STOP_BIT_IDX) begin
        bit_cnt_d = '0;
        if (start_ok && stop_ok && parity_ok) begin
          byte_ok_d = 1'b1;
          byte_d    = shreg_q[8:1];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        shreg_d   = {data_bit, shreg_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != '0) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d     = '0;
        bit_cnt_d = '0;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      // Synchronisers reset to the idle-high bus level so release of reset
      // can never look like a falling edge.
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tmo_q       <= '0;
      byte_q      <= '0;
      byte_ok_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tmo_q       <= tmo_d;
      byte_q      <= byte_d;
      byte_ok_q   <= byte_ok_d;
      err_q       <= err_d;
    end
  end

  assign rx_byte   = byte_q;
  assign byte_ok   = byte_ok_q;
  assign frame_err = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
//   Upstream stage of the scancode-to-ASCII converter. Receives PS/2 bytes,
//   strips E0/F0 prefixes, tracks both shift keys, suppresses typematic
//   repeats and presents the most recently pressed key plus a shift level.
//
//   Build option: PS2_PARITY_CHECK_EN (see ps2_rx_frame) enables rejection
//   of frames with a parity mismatch.
//
//   Ports
//     clk          system clock
//     clrn         asynchronous active-low reset
//     ps2_clk      raw PS/2 clock
//     ps2_data     raw PS/2 data
//     scancode     make code of the last reported key
//     shift        left or right shift held
//     ext          reported key was E0-prefixed
//     key_valid    one-cycle pulse per newly reported press
//     key_down     reported key still held
//     press_count  number of key_valid pulses, modulo 256
//     frame_err    one-cycle pulse on a framing error or timeout
// ----------------------------------------------------------------------------
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       shift,
  output logic       ext,
  output logic       key_valid,
  output logic       key_down,
  output logic [7:0] press_count,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_ok;
  logic       rx_err;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_ok   (rx_ok),
    .frame_err (rx_err)
  );

  dec_state_e state_q, state_d;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       shift_q,   shift_d;
  logic [7:0] scancode_q, scancode_d;
  logic       ext_q,      ext_d;
  logic       key_down_q, key_down_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] press_count_q, press_count_d;

  logic ev_make;
  logic ev_break;
  logic ev_ext;
  logic held_match;

  // Prefix decoder: classifies each accepted byte as prefix, make or break.
  always_comb begin
    state_d  = state_q;
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;

    if (rx_err) begin
      // A damaged frame may have been part of a prefixed sequence; drop it.
      state_d = IDLE;
    end else if (rx_ok) begin
      case (state_q)
        IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_d = EXT;
          end else if (rx_byte == SC_BREAK) begin
            state_d = BRK;
          end else begin
            ev_make = 1'b1;
            state_d = IDLE;
          end
        end
        EXT: begin
          if (rx_byte == SC_BREAK) begin
            state_d = EXT_BRK;
          end else begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          ev_break = 1'b1;
          state_d  = IDLE;
        end
        EXT_BRK: begin
          ev_break = 1'b1;
          ev_ext   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Key tracking: shift flags, held key, repeat suppression, press counter.
  always_comb begin
    shift_l_d     = shift_l_q;
    shift_r_d     = shift_r_q;
    scancode_d    = scancode_q;
    ext_d         = ext_q;
    key_down_d    = key_down_q;
    key_valid_d   = 1'b0;
    press_count_d = press_count_q;

    held_match = key_down_q && (rx_byte == scancode_q) && (ev_ext == ext_q);

    if (ev_make) begin
      if (is_shift_code(rx_byte, ev_ext)) begin
        if (rx_byte == SC_LSHIFT) shift_l_d = 1'b1;
        else                      shift_r_d = 1'b1;
      end else if (!held_match) begin
        // A make of the key already held is a typematic repeat and is dropped.
        scancode_d    = rx_byte;
        ext_d         = ev_ext;
        key_down_d    = 1'b1;
        key_valid_d   = 1'b1;
        press_count_d = press_count_q + 8'd1;
      end
    end

    if (ev_break) begin
      if (is_shift_code(rx_byte, ev_ext)) begin
        if (rx_byte == SC_LSHIFT) shift_l_d = 1'b0;
        else                      shift_r_d = 1'b0;
      end else if (held_match) begin
        key_down_d = 1'b0;
      end
    end

    shift_d = shift_l_d | shift_r_d;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= IDLE;
      shift_l_q     <= 1'b0;
      shift_r_q     <= 1'b0;
      shift_q       <= 1'b0;
      scancode_q    <= '0;
      ext_q         <= 1'b0;
      key_down_q    <= 1'b0;
      key_valid_q   <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_l_q     <= shift_l_d;
      shift_r_q     <= shift_r_d;
      shift_q       <= shift_d;
      scancode_q    <= scancode_d;
      ext_q         <= ext_d;
      key_down_q    <= key_down_d;
      key_valid_q   <= key_valid_d;
      press_count_q <= press_count_d;
    end
  end

  assign scancode    = scancode_q;
  assign shift       = shift_q;
  assign ext         = ext_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign press_count = press_count_q;
  assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_tracker
//   Drives PS/2 frames into ps2_key_tracker and checks every cycle against a
//   keyboard-level model (prefix flags, held key, press counter) that is
//   advanced at the cycle each decoded byte must take effect.
// ----------------------------------------------------------------------------
module tb_ps2_key_tracker;

  localparam int T  = 200;  // timeout used for this bench
  localparam int CW = 8;
  localparam int H  = 4;    // PS/2 half-period in clk cycles

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scancode;
  logic       shift;
  logic       ext;
  logic       key_valid;
  logic       key_down;
  logic [7:0] press_count;
  logic       frame_err;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .scancode    (scancode),
    .shift       (shift),
    .ext         (ext),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .press_count (press_count),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pending expectations.
  typedef struct { logic [7:0] b; int unsigned due; } byte_ev_t;
  typedef struct { int unsigned lo; int unsigned hi; } err_ev_t;
  byte_ev_t bq[$];
  err_ev_t  eq[$];

  // Keyboard-level model.
  bit         m_e0, m_f0, m_shl, m_shr, m_ext, m_down, m_kv;
  logic [7:0] m_code;
  int         m_cnt;

  int n_pass = 0;
  int n_total = 0;
  int err_seen = 0;
  int unsigned last_kv_cyc = 0;
  int unsigned last_stop_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_clear();
    m_e0 = 0; m_f0 = 0; m_shl = 0; m_shr = 0; m_ext = 0; m_down = 0; m_kv = 0;
    m_code = 8'h00; m_cnt = 0;
  endtask

  task automatic model_make(input logic [7:0] b, input bit e);
    if (!e && b == 8'h12) m_shl = 1;
    else if (!e && b == 8'h59) m_shr = 1;
    else if (!(m_down && b == m_code && e == m_ext)) begin
      m_code = b; m_ext = e; m_down = 1; m_kv = 1; m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic model_break(input logic [7:0] b, input bit e);
    if (!e && b == 8'h12) m_shl = 0;
    else if (!e && b == 8'h59) m_shr = 0;
    else if (b == m_code && e == m_ext) m_down = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_f0) begin model_break(b, m_e0); m_e0 = 0; m_f0 = 0; end
    else if (b == 8'hF0) m_f0 = 1;
    else if (!m_e0 && b == 8'hE0) m_e0 = 1;
    else begin model_make(b, m_e0); m_e0 = 0; end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    byte_ev_t be;
    m_kv = 0;
    if (!clrn) begin
      model_clear();
      bq.delete();
      eq.delete();
      check("frame_err", frame_err, 0);
    end else begin
      while (bq.size() > 0 && bq[0].due <= cyc) begin
        be = bq.pop_front();
        model_byte(be.b);
      end
      if (eq.size() > 0 && cyc >= eq[0].lo && cyc <= eq[0].hi) begin
        if (frame_err || cyc == eq[0].hi) begin
          check("frame_err", frame_err, 1);
          if (frame_err) err_seen++;
          void'(eq.pop_front());
          m_e0 = 0; m_f0 = 0;
        end
      end else begin
        check("frame_err", frame_err, 0);
      end
    end
    if (key_valid) last_kv_cyc = cyc;
    check("scancode", scancode, m_code);
    check("shift", shift, m_shl | m_shr);
    check("ext", ext, m_ext);
    check("key_valid", key_valid, m_kv);
    check("key_down", key_down, m_down);
    check("press_count", press_count, m_cnt[7:0]);
  end

  // kind: 0 none, 1 byte expected, 2 framing error expected
  task automatic send_raw(input logic [7:0] b, input logic start_b, input logic stop_b,
                          input logic par_flip, input int nbits, input int kind,
                          output int unsigned last_fall);
    logic [10:0] f;
    f = {stop_b, (~^b) ^ par_flip, b, start_b};
    last_fall = cyc;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = f[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == 10 && kind == 1) bq.push_back('{b: b, due: cyc + 4});
      if (i == 10 && kind == 2) eq.push_back('{lo: cyc + 3, hi: cyc + 3});
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk); ps2_data = 1'b1;
  endtask

  task automatic send_ex(input logic [7:0] b, input logic start_b, input logic stop_b,
                         input logic par_flip);
    int unsigned t;
    int kind;
    kind = (start_b == 1'b0 && stop_b == 1'b1 && !(par_flip && PAR_EN)) ? 1 : 2;
    send_raw(b, start_b, stop_b, par_flip, 11, kind, t);
    last_stop_cyc = t;
  endtask

  task automatic send(input logic [7:0] b);
    send_ex(b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_partial(input int nbits);
    int unsigned t;
    send_raw(8'hA5, 1'b0, 1'b1, 1'b0, nbits, 0, t);
    eq.push_back('{lo: t + T + 2, hi: t + T + 4});
    repeat (T + 10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
  endtask

  logic [7:0] pool [8];
  int e0_base;

  initial begin
    int unsigned t;
    int r;
    logic [7:0] b;

    pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h1C, 8'h1B, 8'h75, 8'h32};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_scancode", scancode, 8'h00);
    check("rst_shift", shift, 0);
    check("rst_ext", ext, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_down", key_down, 0);
    check("rst_press_count", press_count, 8'h00);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk); #1 clrn = 1'b1;
    repeat (4) @(negedge clk);

    // Press and release 1C.
    send(8'h1C);
    check("t1_scancode", scancode, 8'h1C);
    check("t1_key_down", key_down, 1);
    check("t1_count", press_count, 8'd1);
    check("t1_shift", shift, 0);
    check("t1_latency", last_kv_cyc - last_stop_cyc, 4);
    send(8'hF0); send(8'h1C);
    check("t1_released", key_down, 0);
    check("t1_scancode_held", scancode, 8'h1C);

    // Shifted key.
    send(8'h12); send(8'h1C);
    check("t2_shift_on", shift, 1);
    check("t2_count", press_count, 8'd2);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("t2_shift_off", shift, 0);
    check("t2_count_after", press_count, 8'd2);

    // Typematic repeat.
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("t3_count", press_count, 8'd3);
    check("t3_down", key_down, 1);
    send(8'hF0); send(8'h1C);
    check("t3_up", key_down, 0);

    // Extended key, then a non-extended break of the same code.
    send(8'hE0); send(8'h75);
    check("t4_scancode", scancode, 8'h75);
    check("t4_ext", ext, 1);
    check("t4_count", press_count, 8'd4);
    send(8'hF0); send(8'h75);
    check("t4_still_down", key_down, 1);

    // Bad stop, timed-out partial frame, then a good frame.
    e0_base = err_seen;
    send_ex(8'h55, 1'b0, 1'b0, 1'b0);
    send_partial(5);
    send(8'h32);
    check("t5_errs", err_seen - e0_base, 2);
    check("t5_scancode", scancode, 8'h32);
    check("t5_count", press_count, 8'd5);

    // Bad parity.
    e0_base = err_seen;
    send_ex(8'h2D, 1'b0, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("t6_err", err_seen - e0_base, 1);
    check("t6_count", press_count, 8'd5);
`else
    check("t6_scancode", scancode, 8'h2D);
    check("t6_count", press_count, 8'd6);
`endif

    // Reset in the middle of a frame, then 256 distinct presses.
    send_raw(8'h3C, 1'b0, 1'b1, 1'b0, 4, 0, t);
    do_reset();
    @(negedge clk);
    check("t7_rst_count", press_count, 8'd0);
    for (int i = 0; i < 256; i++) begin
      send((i % 2 == 0) ? 8'h1B : 8'h1C);
      if (i == 0)   check("t7_first", press_count, 8'd1);
      if (i == 254) check("t7_255", press_count, 8'd255);
    end
    check("t7_wrap", press_count, 8'd0);

    // Randomised traffic.
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      b = ($urandom_range(0, 8) == 8) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 7)];
      if (r < 6)       send_ex(b, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else if (r < 9)  send_ex(b, 1'b1, 1'b1, 1'b0);
      else if (r < 12) send_partial($urandom_range(1, 9));
      else if (r < 16) send_ex(b, 1'b0, 1'b1, 1'b1);
      else             send(b);
    end

    repeat (10) @(negedge clk);
    check("pending_events", bq.size() + eq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
